// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle for the IF/ID instruction queue.
// The master side is the fetch/decode pair. The slave side is the queue itself.
interface if_id_queue_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic [WIDTH-1:0] in_pc;
  logic [WIDTH-1:0] in_instr;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_pc;
  logic [WIDTH-1:0] out_instr;
  logic             out_ready;
  logic             flush;
  logic [CW-1:0]    count;

  modport master (
    output in_valid, in_pc, in_instr, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_instr, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready, flush,
    output in_ready, out_valid, out_pc, out_instr, count
  );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID circular queue of PC/instruction pairs. It has no fall-through path, so data
// appears at the head one cycle after a push. A branch flush empties it synchronously.
module if_id_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  if_id_queue_if.slave q
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] pc_mem    [DEPTH];
  logic [WIDTH-1:0] instr_mem [DEPTH];

  logic in_ready_c;
  logic out_valid_c;
  logic push_c;
  logic pop_c;

  // Handshake decode; readiness depends on occupancy only (no full-bypass)
  always_comb begin
    in_ready_c  = (count_q < CW'(DEPTH));
    out_valid_c = (count_q != '0);
    push_c      = q.in_valid && in_ready_c && !q.flush;
    pop_c       = out_valid_c && q.out_ready && !q.flush;
  end

  always_comb begin
    q.in_ready  = in_ready_c;
    q.out_valid = out_valid_c;
    q.out_pc    = pc_mem[rd_ptr];
    q.out_instr = instr_mem[rd_ptr];
    q.count     = count_q;
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (q.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; cleared on reset so the stale head reads zero afterwards
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (push_c) begin
      pc_mem[wr_ptr]    <= q.in_pc;
      instr_mem[wr_ptr] <= q.in_instr;
    end
  end
endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: reset, fill/drain, streaming, flush, async reset, empty pop.
module tb_if_id_queue;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  if_id_queue_if #(.DEPTH(4), .WIDTH(32)) q_if ();

  if_id_queue #(.DEPTH(4), .WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .q   (q_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return 32'hC0DE_0000 | pc;
  endfunction

  // Advance one cycle and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    q_if.in_valid  = 1'b0;
    q_if.in_pc     = '0;
    q_if.in_instr  = '0;
    q_if.out_ready = 1'b0;
    q_if.flush     = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #23;
    n_cmp++; if (q_if.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0h expected 0", q_if.out_valid); end
    n_cmp++; if (q_if.out_pc !== 32'h0) begin n_err++; $display("FAIL reset_out_pc: got %0h expected 0", q_if.out_pc); end
    n_cmp++; if (q_if.out_instr !== 32'h0) begin n_err++; $display("FAIL reset_out_instr: got %0h expected 0", q_if.out_instr); end
    n_cmp++; if (q_if.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0h expected 1", q_if.in_ready); end
    n_cmp++; if (q_if.count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", q_if.count); end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_push();
    q_if.in_valid = 1'b1;
    q_if.in_pc    = 32'h0;
    q_if.in_instr = 32'h0022_0000;
    #1;
    n_cmp++; if (q_if.out_valid !== 1'b0) begin n_err++; $display("FAIL no_fallthrough: got %0h expected 0", q_if.out_valid); end
    tick();
    q_if.in_valid = 1'b0;
    n_cmp++; if (q_if.out_valid !== 1'b1) begin n_err++; $display("FAIL single_out_valid: got %0h expected 1", q_if.out_valid); end
    n_cmp++; if (q_if.out_pc !== 32'h0) begin n_err++; $display("FAIL single_out_pc: got %0h expected 0", q_if.out_pc); end
    n_cmp++; if (q_if.out_instr !== 32'h0022_0000) begin n_err++; $display("FAIL single_out_instr: got %0h expected 00220000", q_if.out_instr); end
    n_cmp++; if (q_if.count !== 3'd1) begin n_err++; $display("FAIL single_count: got %0d expected 1", q_if.count); end
    q_if.flush = 1'b1;
    tick();
    q_if.flush = 1'b0;
    n_cmp++; if (q_if.count !== 3'd0) begin n_err++; $display("FAIL single_flush_count: got %0d expected 0", q_if.count); end
  endtask

  task automatic test_fill_drain();
    logic [31:0] pc;
    for (int i = 0; i < 4; i++) begin
      pc = 32'(i * 4);
      q_if.in_valid = 1'b1;
      q_if.in_pc    = pc;
      q_if.in_instr = ins(pc);
      tick();
    end
    n_cmp++; if (q_if.count !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d expected 4", q_if.count); end
    n_cmp++; if (q_if.in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready: got %0h expected 0", q_if.in_ready); end
    q_if.in_pc    = 32'h10;
    q_if.in_instr = ins(32'h10);
    tick();
    q_if.in_valid = 1'b0;
    n_cmp++; if (q_if.count !== 3'd4) begin n_err++; $display("FAIL full_ignore_count: got %0d expected 4", q_if.count); end
    n_cmp++; if (q_if.out_pc !== 32'h0) begin n_err++; $display("FAIL full_ignore_head: got %0h expected 0", q_if.out_pc); end
    q_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc = 32'(i * 4);
      n_cmp++; if (q_if.out_pc !== pc) begin n_err++; $display("FAIL drain_pc[%0d]: got %0h expected %0h", i, q_if.out_pc, pc); end
      n_cmp++; if (q_if.out_instr !== ins(pc)) begin n_err++; $display("FAIL drain_instr[%0d]: got %0h expected %0h", i, q_if.out_instr, ins(pc)); end
      tick();
      if (i == 0) begin
        n_cmp++; if (q_if.in_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_pop: got %0h expected 1", q_if.in_ready); end
      end
    end
    q_if.out_ready = 1'b0;
    n_cmp++; if (q_if.count !== 3'd0) begin n_err++; $display("FAIL drain_count: got %0d expected 0", q_if.count); end
    n_cmp++; if (q_if.out_valid !== 1'b0) begin n_err++; $display("FAIL drain_out_valid: got %0h expected 0", q_if.out_valid); end
    n_cmp++; if (q_if.out_pc !== 32'h0) begin n_err++; $display("FAIL drain_stale_pc: got %0h expected 0", q_if.out_pc); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc;
    for (int i = 0; i < 2; i++) begin
      pc = 32'h08 + 32'(i * 4);
      q_if.in_valid = 1'b1;
      q_if.in_pc    = pc;
      q_if.in_instr = ins(pc);
      tick();
    end
    q_if.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pc = 32'h10 + 32'(i * 4);
      q_if.in_pc    = pc;
      q_if.in_instr = ins(pc);
      pc = 32'h08 + 32'(i * 4);
      n_cmp++; if (q_if.out_pc !== pc) begin n_err++; $display("FAIL stream_pc[%0d]: got %0h expected %0h", i, q_if.out_pc, pc); end
      n_cmp++; if (q_if.count !== 3'd2) begin n_err++; $display("FAIL stream_count[%0d]: got %0d expected 2", i, q_if.count); end
      tick();
    end
    q_if.in_valid = 1'b0;
    n_cmp++; if (q_if.out_pc !== 32'h20) begin n_err++; $display("FAIL stream_tail0: got %0h expected 20", q_if.out_pc); end
    n_cmp++; if (q_if.count !== 3'd2) begin n_err++; $display("FAIL stream_tail_count: got %0d expected 2", q_if.count); end
    tick();
    n_cmp++; if (q_if.out_pc !== 32'h24) begin n_err++; $display("FAIL stream_tail1: got %0h expected 24", q_if.out_pc); end
    n_cmp++; if (q_if.out_instr !== ins(32'h24)) begin n_err++; $display("FAIL stream_tail1_instr: got %0h expected %0h", q_if.out_instr, ins(32'h24)); end
    tick();
    q_if.out_ready = 1'b0;
    n_cmp++; if (q_if.count !== 3'd0) begin n_err++; $display("FAIL stream_empty: got %0d expected 0", q_if.count); end
  endtask

  task automatic test_flush();
    logic [31:0] pc;
    for (int i = 0; i < 3; i++) begin
      pc = 32'h30 + 32'(i * 4);
      q_if.in_valid = 1'b1;
      q_if.in_pc    = pc;
      q_if.in_instr = ins(pc);
      tick();
    end
    n_cmp++; if (q_if.count !== 3'd3) begin n_err++; $display("FAIL preflush_count: got %0d expected 3", q_if.count); end
    q_if.in_pc     = 32'h3C;
    q_if.in_instr  = ins(32'h3C);
    q_if.out_ready = 1'b1;
    q_if.flush     = 1'b1;
    tick();
    idle_inputs();
    n_cmp++; if (q_if.count !== 3'd0) begin n_err++; $display("FAIL flush_count: got %0d expected 0", q_if.count); end
    n_cmp++; if (q_if.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid: got %0h expected 0", q_if.out_valid); end
    q_if.in_valid = 1'b1;
    q_if.in_pc    = 32'h40;
    q_if.in_instr = ins(32'h40);
    tick();
    q_if.in_valid = 1'b0;
    n_cmp++; if (q_if.out_pc !== 32'h40) begin n_err++; $display("FAIL postflush_pc: got %0h expected 40", q_if.out_pc); end
    n_cmp++; if (q_if.count !== 3'd1) begin n_err++; $display("FAIL postflush_count: got %0d expected 1", q_if.count); end
    n_cmp++; if (q_if.out_valid !== 1'b1) begin n_err++; $display("FAIL postflush_valid: got %0h expected 1", q_if.out_valid); end
    q_if.flush = 1'b1;
    tick();
    q_if.flush = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [31:0] pc;
    for (int i = 0; i < 2; i++) begin
      pc = 32'h50 + 32'(i * 4);
      q_if.in_valid = 1'b1;
      q_if.in_pc    = pc;
      q_if.in_instr = ins(pc);
      tick();
    end
    q_if.in_valid = 1'b0;
    n_cmp++; if (q_if.count !== 3'd2) begin n_err++; $display("FAIL prereset_count: got %0d expected 2", q_if.count); end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (q_if.out_valid !== 1'b0) begin n_err++; $display("FAIL async_out_valid: got %0h expected 0", q_if.out_valid); end
    n_cmp++; if (q_if.count !== 3'd0) begin n_err++; $display("FAIL async_count: got %0d expected 0", q_if.count); end
    n_cmp++; if (q_if.out_pc !== 32'h0) begin n_err++; $display("FAIL async_out_pc: got %0h expected 0", q_if.out_pc); end
    @(negedge clk);
    rst = 1'b1;
    tick();
    q_if.in_valid = 1'b1;
    q_if.in_pc    = 32'h0;
    q_if.in_instr = 32'h77;
    tick();
    q_if.in_valid = 1'b0;
    n_cmp++; if (q_if.count !== 3'd1) begin n_err++; $display("FAIL postreset_count: got %0d expected 1", q_if.count); end
    n_cmp++; if (q_if.out_instr !== 32'h77) begin n_err++; $display("FAIL postreset_instr: got %0h expected 77", q_if.out_instr); end
  endtask

  task automatic test_empty_pop();
    q_if.flush = 1'b1;
    tick();
    q_if.flush     = 1'b0;
    q_if.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (q_if.count !== 3'd0) begin n_err++; $display("FAIL empty_count[%0d]: got %0d expected 0", i, q_if.count); end
      n_cmp++; if (q_if.out_valid !== 1'b0) begin n_err++; $display("FAIL empty_valid[%0d]: got %0h expected 0", i, q_if.out_valid); end
      n_cmp++; if (q_if.out_instr !== 32'h77) begin n_err++; $display("FAIL empty_stale[%0d]: got %0h expected 77", i, q_if.out_instr); end
    end
    q_if.out_ready = 1'b0;
    q_if.in_valid  = 1'b1;
    q_if.in_pc     = 32'h60;
    q_if.in_instr  = ins(32'h60);
    tick();
    q_if.in_valid = 1'b0;
    n_cmp++; if (q_if.out_pc !== 32'h60) begin n_err++; $display("FAIL empty_then_push: got %0h expected 60", q_if.out_pc); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    idle_inputs();
    test_reset();
    test_single_push();
    test_fill_drain();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_empty_pop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries (power of two, >= 2).
REQ-002 SHALL have parameter WIDTH, default 32, width of PC and instruction fields.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  fetch stage presents a valid PC/instruction pair.
REQ-006 SHALL have port in_pc  input  WIDTH  PC from fetch stage.
REQ-007 SHALL have port in_instr  input  WIDTH  instruction word from fetch stage.
REQ-008 SHALL have port in_ready  output  1  queue can accept an entry this cycle.
REQ-009 SHALL have port out_valid  output  1  head entry valid for decode stage.
REQ-010 SHALL have port out_pc  output  WIDTH  PC of head entry.
REQ-011 SHALL have port out_instr  output  WIDTH  instruction of head entry.
REQ-012 SHALL have port out_ready  input  1  decode consumes head this cycle (driven low by decode freeze).
REQ-013 SHALL have port flush  input  1  branch taken; discard all queued entries.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-015 SHALL push (write in_pc/in_instr at wr_ptr) on a rising edge when in_valid=1, in_ready=1, flush=0.
REQ-016 SHALL pop (advance rd_ptr) on a rising edge when out_valid=1, out_ready=1, flush=0.
REQ-017 SHALL drive in_ready = (count < DEPTH), combinational from count only; no dependence on out_ready (no full-bypass).
REQ-018 SHALL drive out_valid = (count != 0); out_pc/out_instr = storage at rd_ptr, combinational from storage and rd_ptr.
REQ-019 SHALL NOT fall through: an entry pushed at edge N SHALL appear on out_* no earlier than after edge N (1-cycle latency from in_* to out_*).
REQ-020 SHALL, on simultaneous push and pop (0 < count < DEPTH), leave count unchanged and advance both pointers.
REQ-021 SHALL update count +1 on push only, -1 on pop only, unchanged otherwise; count SHALL never exceed DEPTH or go below 0.
REQ-022 SHALL wrap wr_ptr and rd_ptr modulo DEPTH (DEPTH-1 -> 0).
REQ-023 SHALL, when full (count=DEPTH), ignore in_valid; pop still permitted, in_ready rises the cycle after the pop.
REQ-024 SHALL, when empty, ignore out_ready; out_valid=0 and out_pc/out_instr show stale storage at rd_ptr.
REQ-025 SHALL treat flush synchronously: on edge with flush=1, count:=0, wr_ptr:=0, rd_ptr:=0; same-cycle push and pop both discarded.
REQ-026 SHALL accept a push on the edge after flush deasserts (in_ready=1 during the flush cycle is permitted but has no effect).
REQ-027 SHALL hold all state unchanged when in_valid=0, out_ready=0, flush=0.

Reset
REQ-028 SHALL, while rst=0, asynchronously force count=0, wr_ptr=0, rd_ptr=0, all storage entries to 0.
REQ-029 SHALL give reset values out_valid=0, out_pc=0, out_instr=0, in_ready=1, count=0.
REQ-030 SHALL, on reset asserted mid-operation (any count, any pointers), discard all entries immediately without waiting for clk.
REQ-031 SHALL resume normal push/pop on the first rising edge after rst returns to 1.

Verification
REQ-032 Reset then push PC=0x00,instr=0x00220000 with out_ready=0 -> next cycle out_valid=1, out_pc=0x00, out_instr=0x00220000, count=1.
REQ-033 Push PC=0x00,0x04,0x08,0x0C with out_ready=0 -> count=4, in_ready=0; fifth push (PC=0x10) ignored; then pop 4 -> out_pc sequence 0x00,0x04,0x08,0x0C, count=0.
REQ-034 Hold count=2, in_valid=1 and out_ready=1 for 6 cycles with PCs 0x10..0x24 -> count stays 2, out_pc advances by 4 per cycle, pointers wrap without loss.
REQ-035 Count=3, assert flush with in_valid=1, out_ready=1 for one cycle -> next cycle count=0, out_valid=0; following push PC=0x40 appears as head with count=1.
REQ-036 Count=2, drop rst to 0 between clock edges -> out_valid=0, count=0, out_pc=0 before the next edge; after release push PC=0x00 -> count=1.
REQ-037 Empty queue, out_ready=1, in_valid=0 for 3 cycles -> count remains 0, no pointer movement, out_valid=0.
